// File: rtl/zion_stream_pkg.sv
// Shared stream types for the zion register-slice library.
// Holds the skid-buffer state encoding and occupancy sizing.
package zion_stream_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/zion_skid_reg_slice_if.sv
// Stream handshake bundle for zion_skid_reg_slice.
// The slave modport is the slice; the master modport drives it.
interface zion_skid_reg_slice_if #(
    parameter int unsigned WIDTH = 8
) ();
    import zion_stream_pkg::*;

    logic             iClr;
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;
    logic [CNT_W-1:0] oCnt;

    modport master (
        output iClr, iVld, iDat, iRdy,
        input  oRdy, oVld, oDat, oCnt
    );

    modport slave (
        input  iClr, iVld, iDat, iRdy,
        output oRdy, oVld, oDat, oCnt
    );

endinterface

// File: rtl/zion_clr_en_dff_sp.sv
// WIDTH-bit register with synchronous reset, clear and load enable.
// Reset takes priority over clear, clear over enable; both load INI_DATA.
module zion_clr_en_dff_sp #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat <= INI_DATA;
        end else if (i_clr) begin
            r_dat <= INI_DATA;
        end else if (i_en) begin
            r_dat <= i_dat;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/zion_skid_reg_slice.sv
// Two-entry valid/ready skid slice: registered data, valid and ready.
// No combinational path from downstream iRdy to upstream oRdy.
module zion_skid_reg_slice
    import zion_stream_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input logic                   clk,
    input logic                   rst,
    zion_skid_reg_slice_if.slave  bus
);

    skid_state_e      r_state;
    logic             r_vld;
    logic             r_rdy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_acc;
    logic             w_take;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_skid_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_acc  = bus.iVld && r_rdy;
    assign w_take = r_vld && bus.iRdy;

    always_comb begin
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
        w_main_d  = bus.iDat;
        w_skid_d  = bus.iDat;
        case (r_state)
            EMPTY: w_main_en = w_acc;
            ONE: begin
                w_main_en = w_acc && w_take;
                w_skid_en = w_acc && !w_take;
            end
            FULL: begin
                // Drain: skid beat moves up to main, skid returns to idle value.
                w_main_en = w_take;
                w_main_d  = w_skid_q;
                w_skid_en = w_take;
                w_skid_d  = INI_DATA;
            end
            default: ;
        endcase
    end

    zion_clr_en_dff_sp #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.iClr),
        .i_en  (w_main_en),
        .i_dat (w_main_d),
        .o_dat (w_main_q)
    );

    zion_clr_en_dff_sp #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI_DATA)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .i_clr (bus.iClr),
        .i_en  (w_skid_en),
        .i_dat (w_skid_d),
        .o_dat (w_skid_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_vld   <= 1'b0;
            r_rdy   <= 1'b0;
            r_cnt   <= '0;
        end else if (bus.iClr) begin
            r_state <= EMPTY;
            r_vld   <= 1'b0;
            r_rdy   <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_rdy <= 1'b1;
                    if (w_acc) begin
                        r_state <= ONE;
                        r_vld   <= 1'b1;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ONE: begin
                    if (w_acc && !w_take) begin
                        r_state <= FULL;
                        r_rdy   <= 1'b0;
                        r_cnt   <= CNT_W'(2);
                    end else if (!w_acc && w_take) begin
                        r_state <= EMPTY;
                        r_vld   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                FULL: begin
                    if (w_take) begin
                        r_state <= ONE;
                        r_rdy   <= 1'b1;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_vld   <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.oRdy = r_rdy;
    assign bus.oVld = r_vld;
    assign bus.oCnt = r_cnt;
    assign bus.oDat = w_main_q;

endmodule

// File: tb/tb_zion_skid_reg_slice.sv
// Bench for zion_skid_reg_slice: directed scenarios plus random stalls,
// with a two-deep queue model checked on every falling edge.
module tb_zion_skid_reg_slice;

    localparam int unsigned      WIDTH = 8;
    localparam logic [WIDTH-1:0] INI   = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    zion_skid_reg_slice_if #(.WIDTH(WIDTH)) bus ();

    zion_skid_reg_slice #(
        .WIDTH    (WIDTH),
        .INI_DATA (INI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_taken  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of beats held by the slice, capacity two.
    logic [WIDTH-1:0] q[$];
    logic             rdy_exp   = 1'b0;
    logic             stall_p   = 1'b0;
    logic [WIDTH-1:0] stall_dat = '0;
    logic             pend_p    = 1'b0;
    logic [WIDTH-1:0] pend_dat  = '0;

    initial begin
        forever begin
            @(negedge clk);
            chk("mdl_vld", bus.oVld, q.size() != 0);
            chk("mdl_cnt", bus.oCnt, q.size());
            chk("mdl_rdy", bus.oRdy, rdy_exp);
            if (bus.oVld && q.size() != 0) chk("mdl_dat", bus.oDat, q[0]);
            if (stall_p) begin
                chk("stall_vld", bus.oVld, 1);
                chk("stall_dat", bus.oDat, stall_dat);
            end
            if (pend_p && !(bus.iVld && bus.iDat == pend_dat))
                $error("upstream dropped or changed an unaccepted beat");

            stall_p   = bus.oVld && !bus.iRdy && !rst && !bus.iClr;
            stall_dat = bus.oDat;
            pend_p    = bus.iVld && !bus.oRdy && !rst && !bus.iClr;
            pend_dat  = bus.iDat;

            if (rst) begin
                q.delete();
                rdy_exp = 1'b0;
            end else if (bus.iClr) begin
                q.delete();
                rdy_exp = 1'b1;
            end else begin
                if (bus.oVld && bus.iRdy && q.size() != 0) begin
                    void'(q.pop_front());
                    n_taken++;
                end
                if (bus.iVld && bus.oRdy) q.push_back(bus.iDat);
                rdy_exp = (q.size() < 2);
            end
        end
    end

    logic             acc;
    int               ph;
    int               taken0;
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] bp_exp[3];

    initial begin
        bus.iClr = 1'b0;
        bus.iVld = 1'b0;
        bus.iRdy = 1'b0;
        bus.iDat = '0;

        // Reset held for three cycles, then released
        repeat (3) begin
            @(negedge clk);
            chk("rst_vld", bus.oVld, 0);
            chk("rst_rdy", bus.oRdy, 0);
            chk("rst_cnt", bus.oCnt, 0);
            chk("rst_dat", bus.oDat, INI);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("rel_rdy0", bus.oRdy, 0);
        @(negedge clk); chk("rel_rdy1", bus.oRdy, 1);
        chk("rel_dat", bus.oDat, INI);

        // Streaming 0x01..0x10 at full rate
        for (int i = 0; i <= 16; i++) begin
            @(posedge clk); #1;
            bus.iRdy = 1'b1;
            bus.iVld = (i < 16);
            bus.iDat = WIDTH'(i + 1);
            @(negedge clk);
            if (i > 0) begin
                chk("stream_vld", bus.oVld, 1);
                chk("stream_dat", bus.oDat, i);
                chk("stream_cnt", bus.oCnt, 1);
            end
        end
        @(posedge clk); #1;
        @(negedge clk); chk("stream_empty", bus.oVld, 0);

        // Backpressure fill
        @(posedge clk); #1 bus.iRdy = 1'b0; bus.iVld = 1'b1; bus.iDat = 8'hA1;
        @(posedge clk); #1 bus.iDat = 8'hA2;
        @(posedge clk); #1 bus.iDat = 8'hA3;
        @(negedge clk);
        chk("bp_cnt", bus.oCnt, 2);
        chk("bp_rdy", bus.oRdy, 0);
        chk("bp_dat", bus.oDat, 8'hA1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold_cnt", bus.oCnt, 2);
        chk("bp_hold_dat", bus.oDat, 8'hA1);
        @(posedge clk); #1 bus.iRdy = 1'b1;
        bp_exp[0] = 8'hA1; bp_exp[1] = 8'hA2; bp_exp[2] = 8'hA3;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.oVld && bus.iRdy) got.push_back(bus.oDat);
            acc = bus.iVld && bus.oRdy;
            @(posedge clk); #1;
            if (acc) bus.iVld = 1'b0;
        end
        chk("bp_n", got.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got.size()) chk("bp_order", got[i], bp_exp[i]);

        // Flush while FULL with a beat on offer
        @(posedge clk); #1 bus.iRdy = 1'b0; bus.iVld = 1'b1; bus.iDat = 8'h55;
        @(posedge clk); #1 bus.iDat = 8'h66;
        @(posedge clk); #1 bus.iDat = 8'h77; bus.iClr = 1'b1;
        @(negedge clk); chk("fl_full", bus.oCnt, 2);
        @(posedge clk); #1 bus.iClr = 1'b0; bus.iVld = 1'b0; bus.iRdy = 1'b1;
        @(negedge clk);
        chk("fl_vld", bus.oVld, 0);
        chk("fl_cnt", bus.oCnt, 0);
        chk("fl_dat", bus.oDat, INI);
        chk("fl_rdy", bus.oRdy, 1);
        repeat (3) begin
            @(negedge clk);
            chk("fl_no77", bus.oVld && bus.oDat == 8'h77, 0);
        end

        // Reset mid-operation, with a simultaneous clear
        @(posedge clk); #1 bus.iRdy = 1'b0; bus.iVld = 1'b1; bus.iDat = 8'h11;
        @(posedge clk); #1 bus.iVld = 1'b0;
        @(negedge clk); chk("rm_one", bus.oCnt, 1);
        @(posedge clk); #1;
        rst = 1'b1; bus.iClr = 1'b1; bus.iVld = 1'b1; bus.iRdy = 1'b1; bus.iDat = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; bus.iClr = 1'b0; bus.iVld = 1'b0; bus.iRdy = 1'b0;
        @(negedge clk);
        chk("rm_vld", bus.oVld, 0);
        chk("rm_cnt", bus.oCnt, 0);
        chk("rm_rdy", bus.oRdy, 0);
        chk("rm_dat", bus.oDat, INI);
        @(negedge clk); chk("rm_rdy1", bus.oRdy, 1);

        // Random valid/ready with rare flushes
        taken0 = n_taken;
        for (int c = 0; c < 10000; c++) begin
            ph = (c / 1000) % 4;
            @(negedge clk);
            acc = bus.iVld && bus.oRdy;
            @(posedge clk); #1;
            if (!bus.iVld || acc || bus.iClr) begin
                bus.iVld = ($urandom_range(0, 7) < 8 - ph * 2);
                bus.iDat = WIDTH'($urandom);
            end
            bus.iRdy = ($urandom_range(0, 7) < 2 + ph * 2);
            bus.iClr = ($urandom_range(0, 499) == 0);
        end
        chk("rand_progress", (n_taken - taken0) > 1000, 1);

        // Drain: let any pending beat in, then empty the slice
        @(posedge clk); #1 bus.iClr = 1'b0; bus.iRdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = bus.iVld && bus.oRdy;
            @(posedge clk); #1;
            if (acc) bus.iVld = 1'b0;
        end
        @(negedge clk);
        chk("drain_q", q.size(), 0);
        chk("drain_vld", bus.oVld, 0);
        chk("drain_iVld", bus.iVld, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
